// File: rtl/mem_check_pkg.sv
// Shared types for the data-memory write checker: FSM state encoding and
// table-entry sizing helper.
package mem_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_t;

    function automatic int entry_width(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/mem_check_table.sv
// Expected-store table: DEPTH entries of {address, data}, one synchronous
// write port, one asynchronous read port. Storage is intentionally unreset.
module mem_check_table
    import mem_check_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [AW-1:0]            waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [AW-1:0]            raddr,
    output logic [DW-1:0]            rdata
);
    localparam int EW = entry_width(AW, DW);

    logic [EW-1:0] mem [DEPTH];

    // Table write; contents persist across reset so a re-start reruns the check
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= {waddr, wdata};
        end
    end

    assign {raddr, rdata} = mem[ridx];

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the data-memory write port and compares the ordered store stream
// against a loadable table. Optional timeout: MEM_WRITE_CHECKER_TIMEOUT_EN.
module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [AW-1:0]            DataAdr,
    input  logic [DW-1:0]            WriteData,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_idx,
    input  logic [AW-1:0]            exp_addr,
    input  logic [DW-1:0]            exp_data,
    input  logic [$clog2(DEPTH):0]   num_exp,
    input  logic                     start,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [$clog2(DEPTH)-1:0] fail_idx,
    output logic [AW-1:0]            fail_addr,
    output logic [DW-1:0]            fail_data,
    output logic [CW-1:0]            cycles
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    ,
    input  logic [CW-1:0]            timeout_lim,
    output logic                     timed_out
`endif
);
    localparam int IW = $clog2(DEPTH);
    localparam int NW = IW + 1;
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
    localparam logic [CW-1:0] CYC_MAX = {CW{1'b1}};

    chk_state_t     state_r, state_next;
    logic [IW-1:0]  ptr_r;
    logic [NW-1:0]  num_r;
    logic [AW-1:0]  tbl_addr;
    logic [DW-1:0]  tbl_data;
    logic [NW-1:0]  num_clamped;
    logic [CW-1:0]  cycles_inc;
    logic           start_ok;
    logic           store_hit;
    logic           last_entry;
    logic           tmo_hit;

    mem_check_table #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_table (
        .clk   (clk),
        .we    (exp_we && (state_r != RUN)),
        .widx  (exp_idx),
        .waddr (exp_addr),
        .wdata (exp_data),
        .ridx  (ptr_r),
        .raddr (tbl_addr),
        .rdata (tbl_data)
    );

    // Comparator, saturating increment and decision conditions
    always_comb begin
        num_clamped = (num_exp > DEPTH_N) ? DEPTH_N : num_exp;
        start_ok    = start && (state_r != RUN);
        cycles_inc  = (cycles == CYC_MAX) ? cycles : cycles + CW'(1);
        store_hit   = (DataAdr == tbl_addr) && (WriteData == tbl_data);
        last_entry  = ({1'b0, ptr_r} == (num_r - NW'(1)));
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
        tmo_hit     = (timeout_lim != CW'(0)) && (cycles_inc == timeout_lim);
`else
        tmo_hit     = 1'b0;
`endif
    end

    // Next-state logic; a store decides before a coincident timeout
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE, PASS, FAIL: begin
                if (start_ok) begin
                    state_next = (num_clamped == NW'(0)) ? PASS : RUN;
                end else begin
                    state_next = state_r;
                end
            end
            RUN: begin
                if (MemWrite) begin
                    if (!store_hit) begin
                        state_next = FAIL;
                    end else if (last_entry) begin
                        state_next = PASS;
                    end else begin
                        state_next = RUN;
                    end
                end else if (tmo_hit) begin
                    state_next = FAIL;
                end else begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Pointer, cycle counter, registered flags and failure capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r     <= '0;
            num_r     <= '0;
            cycles    <= '0;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_idx  <= '0;
            fail_addr <= '0;
            fail_data <= '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
        end else begin
            busy <= (state_next == RUN);
            pass <= (state_next == PASS);
            fail <= (state_next == FAIL);
            if (start_ok) begin
                ptr_r     <= '0;
                num_r     <= num_clamped;
                cycles    <= '0;
                fail_idx  <= '0;
                fail_addr <= '0;
                fail_data <= '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
                timed_out <= 1'b0;
`endif
            end else if (state_r == RUN) begin
                cycles <= cycles_inc;
                if (MemWrite) begin
                    if (!store_hit) begin
                        fail_idx  <= ptr_r;
                        fail_addr <= DataAdr;
                        fail_data <= WriteData;
                    end else if (!last_entry) begin
                        ptr_r <= ptr_r + IW'(1);
                    end
                end else if (tmo_hit) begin
                    fail_idx  <= ptr_r;
                    fail_addr <= '0;
                    fail_data <= '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
                    timed_out <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed scoreboard bench for mem_write_checker; timeout scenarios are
// exercised when MEM_WRITE_CHECKER_TIMEOUT_EN is defined.
module tb_mem_write_checker;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int IW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            reset;
    logic            MemWrite;
    logic [AW-1:0]   DataAdr;
    logic [DW-1:0]   WriteData;
    logic            exp_we;
    logic [IW-1:0]   exp_idx;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_data;
    logic [IW:0]     num_exp;
    logic            start;
    logic            busy, pass, fail;
    logic [IW-1:0]   fail_idx;
    logic [AW-1:0]   fail_addr;
    logic [DW-1:0]   fail_data;
    logic [CW-1:0]   cycles;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    logic [CW-1:0]   timeout_lim;
    logic            timed_out;
`endif

    mem_write_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .exp_we      (exp_we),
        .exp_idx     (exp_idx),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .num_exp     (num_exp),
        .start       (start),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .fail_idx    (fail_idx),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data),
        .cycles      (cycles)
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
        ,
        .timeout_lim (timeout_lim),
        .timed_out   (timed_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pass;
        logic          fail;
        logic          busy;
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_we   = 1'b1;
        exp_idx  = IW'(idx);
        exp_addr = a;
        exp_data = d;
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic do_start(input int n);
        num_exp = (IW+1)'(n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic push_pass(input int cyc);
        exp_t e;
        e = '{pass: 1'b1, fail: 1'b0, busy: 1'b0, idx: '0, addr: '0, data: '0, cyc: CW'(cyc)};
        sb.push_back(e);
    endtask

    task automatic push_fail(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d, input int cyc);
        exp_t e;
        e = '{pass: 1'b0, fail: 1'b1, busy: 1'b0, idx: IW'(idx), addr: a, data: d, cyc: CW'(cyc)};
        sb.push_back(e);
    endtask

    // Bounded wait for a decision, then pop and compare the oldest expectation
    task automatic wait_outcome(input string tag);
        exp_t e;
        int   n = 0;
        while (!(pass || fail) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        assert (pass || fail) else begin
            errors++;
            $error("FAIL %s_decide: observed no decision expected pass or fail", tag);
        end
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_pass"}, 64'(pass), 64'(e.pass));
            chk({tag, "_fail"}, 64'(fail), 64'(e.fail));
            chk({tag, "_busy"}, 64'(busy), 64'(e.busy));
            chk({tag, "_cycles"}, 64'(cycles), 64'(e.cyc));
            chk({tag, "_fidx"}, 64'(fail_idx), 64'(e.idx));
            chk({tag, "_faddr"}, 64'(fail_addr), 64'(e.addr));
            chk({tag, "_fdata"}, 64'(fail_data), 64'(e.data));
        end
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        exp_we    = 1'b0;
        exp_idx   = '0;
        exp_addr  = '0;
        exp_data  = '0;
        num_exp   = '0;
        start     = 1'b0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
        timeout_lim = '0;
`endif
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_fail", 64'(fail), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single entry, store lands on the fifth RUN cycle
        load(0, 32'd100, 32'd7);
        do_start(1);
        chk("t1_busy", 64'(busy), 64'd1);
        repeat (4) tick();
        push_pass(5);
        store(32'd100, 32'd7, 0);
        wait_outcome("t1");

        // Zero entries passes straight away
        push_pass(0);
        do_start(0);
        wait_outcome("t4_zero");

        // Wrong store in the start cycle must not be checked
        num_exp   = 2'd1;
        start     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'd100;
        WriteData = 32'd99;
        tick();
        start     = 1'b0;
        MemWrite  = 1'b0;
        chk("t4_startstore_fail", 64'(fail), 64'd0);
        chk("t4_startstore_busy", 64'(busy), 64'd1);
        push_pass(1);
        store(32'd100, 32'd7, 0);
        wait_outcome("t4_after");

        // num_exp above DEPTH is clamped, so eight stores decide
        for (int i = 0; i < DEPTH; i++) load(i, 32'h1000 + 32'(4 * i), 32'(3 * i + 1));
        do_start(15);
        push_pass(DEPTH);
        for (int i = 0; i < DEPTH; i++) store(32'h1000 + 32'(4 * i), 32'(3 * i + 1), 0);
        wait_outcome("clamp");

        // Three entries with idle gaps
        load(0, 32'd84, 32'd7);
        load(1, 32'd88, 32'd11);
        load(2, 32'd100, 32'd7);
        do_start(3);
        push_pass(6);
        store(32'd84, 32'd7, 2);
        store(32'd88, 32'd11, 1);
        chk("t2_mid_pass", 64'(pass), 64'd0);
        chk("t2_mid_busy", 64'(busy), 64'd1);
        store(32'd100, 32'd7, 0);
        wait_outcome("t2");
        store(32'd20, 32'd5, 0);
        chk("t2_after_pass", 64'(pass), 64'd1);
        chk("t2_after_fail", 64'(fail), 64'd0);
        chk("t2_after_cycles", 64'(cycles), 64'd6);

        // Data mismatch on the second store
        do_start(3);
        push_fail(1, 32'd88, 32'd12, 2);
        store(32'd84, 32'd7, 0);
        store(32'd88, 32'd12, 0);
        wait_outcome("t3");
        store(32'd88, 32'd11, 0);
        chk("t3_sticky_fail", 64'(fail), 64'd1);
        chk("t3_sticky_pass", 64'(pass), 64'd0);
        chk("t3_sticky_idx", 64'(fail_idx), 64'd1);

        // Asynchronous reset mid-RUN, then rerun the retained table
        do_start(3);
        store(32'd84, 32'd7, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_pass", 64'(pass), 64'd0);
        chk("t5_rst_fail", 64'(fail), 64'd0);
        chk("t5_rst_cycles", 64'(cycles), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        do_start(3);
        push_pass(3);
        store(32'd84, 32'd7, 0);
        store(32'd88, 32'd11, 0);
        store(32'd100, 32'd7, 0);
        wait_outcome("t5_rerun");

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
        timeout_lim = 16'd10;
        do_start(1);
        push_fail(0, 32'd0, 32'd0, 10);
        wait_outcome("tmo");
        chk("tmo_flag", 64'(timed_out), 64'd1);
        timeout_lim = 16'd0;
        do_start(1);
        repeat (100) tick();
        chk("tmo_off_busy", 64'(busy), 64'd1);
        chk("tmo_off_flag", 64'(timed_out), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-checking monitor on the processor data-memory write port (`MemWrite`/`DataAdr`/`WriteData`).
- Replaces ad-hoc single-address checks in benches with a parametrised check. It compares the ordered stream of stores against a loadable table of expected (address, data) pairs.
- Reports pass/fail, the failing index and the elapsed cycles.
- Sits beside `top` in benches; can also be instantiated on-chip for FPGA smoke tests.

Parameters:
- `AW`, 32, address width of `DataAdr`.
- `DW`, 32, data width of `WriteData`.
- `DEPTH`, 8, number of expected-store entries (power of two, ≥2).
- `CW`, 16, width of the cycle counter and timeout limit.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `MemWrite` input 1: store strobe from the processor.
- `DataAdr` input `AW`: store address.
- `WriteData` input `DW`: store data.
- `exp_we` input 1: table write strobe.
- `exp_idx` input `$clog2(DEPTH)`: table write index.
- `exp_addr` input `AW`: expected address for the entry.
- `exp_data` input `DW`: expected data for the entry.
- `num_exp` input `$clog2(DEPTH)+1`: number of entries to check, 0..`DEPTH`; sampled on start.
- `start` input 1: arm the checker.
- `busy` output 1: high in RUN.
- `pass` output 1: sticky pass flag.
- `fail` output 1: sticky fail flag.
- `fail_idx` output `$clog2(DEPTH)`: entry index at which the failure occurred.
- `fail_addr` output `AW`: `DataAdr` of the offending store.
- `fail_data` output `DW`: `WriteData` of the offending store.
- `cycles` output `CW`: clocks spent in RUN, saturating.

Behaviour:
- States: IDLE, RUN, PASS, FAIL.
- Reset (async): state←IDLE. `busy`, `pass`, `fail`, `fail_idx`, `fail_addr`, `fail_data`, `cycles`, and the pointer all ←0. The table contents are NOT cleared.
- Table write: on a posedge with `exp_we`=1 and state≠RUN, `table[exp_idx]` ← {`exp_addr`, `exp_data`}. `exp_we` is ignored in RUN.
- `start` is accepted in IDLE, PASS or FAIL:
  - ptr←0; `cycles`←0; `pass`/`fail`/`fail_*`←0; `num_exp` latched.
  - Next state is RUN, or PASS directly if latched `num_exp`=0.
  - `start` is ignored in RUN.
- A `MemWrite` in the same cycle as an accepted `start` is not checked. Checking begins the cycle after.
- RUN, each posedge:
  - `cycles` increments and saturates at 2^`CW`−1.
  - If `MemWrite`=1, the store is compared with `table[ptr]`, both address and data exactly.
  - Match and ptr=`num_exp`−1 → PASS.
  - Match otherwise → ptr+1.
  - Mismatch → FAIL; `fail_idx`←ptr; `fail_addr`/`fail_data`←the offending store.
  - `MemWrite`=0 cycles do nothing except the count.
- PASS/FAIL: sticky until reset or `start`.
  - Further stores in PASS are ignored.
  - `busy`=0 in PASS and FAIL.
- Flags are registered. `pass` or `fail` rises one clock after the deciding store edge.
- Reset mid-RUN: immediate return to IDLE with all flags cleared. The table survives, so re-`start` reruns the same check.
- Pointer never wraps: the checker leaves RUN at `num_exp`. A `num_exp`>`DEPTH` is clamped to `DEPTH`.

Optional Feature:
- Macro `MEM_WRITE_CHECKER_TIMEOUT_EN`.
- With it defined:
  - Extra input `timeout_lim` [`CW`].
  - In RUN, when `cycles` reaches `timeout_lim` (nonzero) without a decision → FAIL, with `fail_idx`=ptr and `fail_addr`/`fail_data`=0.
  - An extra output `timed_out` (1) is set; it is cleared by reset or `start`.
  - `timeout_lim`=0 disables the timeout.
- Without it: no timeout; RUN persists until a match or mismatch decides.

Decomposition:
- Package `mem_check_pkg`:
  - State enum `chk_state_t` {IDLE, RUN, PASS, FAIL}.
  - Entry struct width constant helper.
- One sub-module `mem_check_table`: the `DEPTH`×(`AW`+`DW`) register file.
  - One write port, one asynchronous read port indexed by ptr.
  - No reset on the storage.
- FSM, comparator and counter live in the top-level module.

Test Plan:
- Single entry {100, 7}, `num_exp`=1; start; store (100, 7) on cycle 5 → `pass`=1 one clock later, `busy`=0, `cycles`=5.
- Three entries {(84,7),(88,11),(100,7)}; stores in order with idle gaps → `pass`=1 after the third store. A fourth store to 20 afterwards leaves `pass`=1 and `fail`=0.
- Same table; second store (88, 12) → `fail`=1, `fail_idx`=1, `fail_addr`=88, `fail_data`=12. A following correct store does not clear `fail`.
- `num_exp`=0; start → `pass`=1 the next cycle. Also: `MemWrite` asserted in the start cycle with wrong data → no fail.
- Reset asserted asynchronously mid-RUN after one matched store → all outputs 0 immediately. Re-start with the same table, then the correct stores → `pass`=1, confirming the table was retained.
- With `MEM_WRITE_CHECKER_TIMEOUT_EN`, `timeout_lim`=10 and no stores → `fail`=1 and `timed_out`=1 with `cycles`=10. With `timeout_lim`=0 and 100 idle cycles → still `busy`=1.
